// File: rtl/lea_pkg.sv
// Shared LEA definitions: block/byte widths, serializer FSM state and index sizing.
// No logic and no latency; consumed by the serializer and its byte counter.
package lea_pkg;

  localparam int LEA_BLOCK_W = 128;
  localparam int LEA_BYTE_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A one-byte block still needs one index bit to be a legal vector.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/lea_byte_counter.sv
// Byte index counter for the block serializer; clear wins over inc, saturates at NBYTES-1.
// Count updates on the edge after clear/inc; no backpressure of its own.
module lea_byte_counter
  import lea_pkg::*;
#(
  parameter int NBYTES = 16,
  localparam int CW    = idx_width(NBYTES)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX = CW'(NBYTES - 1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX);

endmodule

// File: rtl/lea_block_serializer.sv
// Serializes one captured LEA block into bytes; first byte valid one cycle after Ld.
// Dready=0 stalls with Dout/Last held; Ld is ignored until the block is fully sent.
module lea_block_serializer
  import lea_pkg::*;
#(
  parameter int NBYTES    = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Ld,
  input  logic [LEA_BYTE_W*NBYTES-1:0] Blk,
  output logic                         Busy,
  output logic [LEA_BYTE_W-1:0]        Dout,
  output logic                         Dvalid,
  input  logic                         Dready,
  output logic                         Last,
  output logic                         Done
);

  localparam int BW = LEA_BYTE_W * NBYTES;
  localparam int CW = idx_width(NBYTES);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] blk_q;
  logic [CW-1:0] idx;
  logic [CW-1:0] sel;
  logic          at_max;
  logic          load;
  logic          xfer;
  logic          done_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Ld) state_nxt = SEND;
      SEND:    if (Dready && at_max) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream position k maps to byte k or byte NBYTES-1-k of the captured block.
  assign sel = MSB_FIRST ? (CW'(NBYTES - 1) - idx) : idx;

  always_comb begin
    Busy   = 1'b0;
    Dvalid = 1'b0;
    Last   = 1'b0;
    Dout   = '0;
    load   = 1'b0;
    xfer   = 1'b0;
    case (state)
      IDLE: begin
        load = Ld;
      end
      SEND: begin
        Busy   = 1'b1;
        Dvalid = 1'b1;
        Last   = at_max;
        Dout   = blk_q[sel*LEA_BYTE_W +: LEA_BYTE_W];
        xfer   = Dready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blk_q <= '0;
    end else if (load) begin
      blk_q <= Blk;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && at_max;
    end
  end

  assign Done = done_q;

  lea_byte_counter #(
    .NBYTES (NBYTES)
  ) u_byte_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (load),
    .inc    (xfer),
    .count  (idx),
    .at_max (at_max)
  );

endmodule

// File: tb/tb_lea_block_serializer.sv
// Directed bench: LSB-first and MSB-first serializers share stimulus; a one-byte instance is checked separately.
module tb_lea_block_serializer;

  localparam int NB = 16;
  localparam logic [127:0] BLK_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] BLK_B = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld = 1'b0;
  logic         dready = 1'b0;
  logic [127:0] blk = '0;

  logic       busy0, dvalid0, last0, done0;
  logic [7:0] dout0;
  logic       busy1, dvalid1, last1, done1;
  logic [7:0] dout1;

  logic       ld2 = 1'b0;
  logic       dready2 = 1'b0;
  logic [7:0] blk2 = '0;
  logic       busy2, dvalid2, last2, done2;
  logic [7:0] dout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lea_block_serializer #(.NBYTES(NB), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk(clk), .Reset(rst), .Ld(ld), .Blk(blk), .Busy(busy0), .Dout(dout0),
    .Dvalid(dvalid0), .Dready(dready), .Last(last0), .Done(done0)
  );

  lea_block_serializer #(.NBYTES(NB), .MSB_FIRST(1'b1)) dut_msb (
    .Clk(clk), .Reset(rst), .Ld(ld), .Blk(blk), .Busy(busy1), .Dout(dout1),
    .Dvalid(dvalid1), .Dready(dready), .Last(last1), .Done(done1)
  );

  lea_block_serializer #(.NBYTES(1), .MSB_FIRST(1'b0)) dut_one (
    .Clk(clk), .Reset(rst), .Ld(ld2), .Blk(blk2), .Busy(busy2), .Dout(dout2),
    .Dvalid(dvalid2), .Dready(dready2), .Last(last2), .Done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] b, input int k, input bit msb);
    int p;
    p = msb ? (NB - 1 - k) : k;
    return b[p*8 +: 8];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_vld0"}, dvalid0, 0);
    chk({tag, "_dout0"}, dout0, 0);
    chk({tag, "_last0"}, last0, 0);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_vld1"}, dvalid1, 0);
    chk({tag, "_dout1"}, dout1, 0);
    chk({tag, "_last1"}, last1, 0);
  endtask

  // Called at a negedge; Ld is high for exactly one rising edge.
  task automatic load(input logic [127:0] b);
    blk = b;
    ld  = 1'b1;
    @(negedge clk);
    ld  = 1'b0;
  endtask

  // Starts at the negedge where the first byte should already be valid.
  task automatic stream(input logic [127:0] b, input bit bp, input bit spam, input int stop_at);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k < stop_at && cyc < 200) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      chk("vld0", dvalid0, 1);
      chk("busy0", busy0, 1);
      chk("dout0", dout0, byte_of(b, k, 1'b0));
      chk("last0", last0, k == NB - 1);
      chk("vld1", dvalid1, 1);
      chk("dout1", dout1, byte_of(b, k, 1'b1));
      chk("last1", last1, k == NB - 1);
      chk("done0_mid", done0, 0);
      dready = rdy;
      if (spam) begin
        ld  = 1'b1;
        blk = '1;
      end
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    ld = 1'b0;
    chk("xfer_count", k, stop_at);
    if (stop_at == NB) begin
      chk("done0", done0, 1);
      chk("done1", done1, 1);
      chk_idle("end");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_idle("rst");
    chk("rst_done0", done0, 0);
    chk("rst_vld2", dvalid2, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full-rate stream; Dready stays high into idle afterwards.
    load(BLK_A);
    stream(BLK_A, 1'b0, 1'b0, NB);
    @(negedge clk);
    chk("done0_pulse", done0, 0);
    chk_idle("idle_rdy");

    // Back-pressure 1,0,0 repeating.
    load(BLK_A);
    stream(BLK_A, 1'b1, 1'b0, NB);
    @(negedge clk);

    // All-ones Ld throughout SEND, including the Last cycle.
    load(BLK_A);
    stream(BLK_A, 1'b1, 1'b1, NB);
    @(negedge clk);
    chk_idle("after_spam");

    // Abort mid-block with an asynchronous reset pulse.
    load(BLK_A);
    stream(BLK_A, 1'b0, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_done0", done0, 0);
    @(negedge clk);
    rst = 1'b0;
    load(128'h1);
    stream(128'h1, 1'b0, 1'b0, NB);

    // Back-to-back: reload the cycle after Done.
    @(negedge clk);
    chk("b2b_done0", done0, 0);
    chk("b2b_busy0", busy0, 0);
    load(BLK_B);
    stream(BLK_B, 1'b0, 1'b0, NB);
    @(negedge clk);

    // One-byte block with a single stall cycle.
    blk2 = 8'hA5;
    ld2  = 1'b1;
    @(negedge clk);
    ld2  = 1'b0;
    chk("one_vld", dvalid2, 1);
    chk("one_dout", dout2, 8'hA5);
    chk("one_last", last2, 1);
    @(negedge clk);
    chk("one_stall_dout", dout2, 8'hA5);
    chk("one_stall_last", last2, 1);
    dready2 = 1'b1;
    @(negedge clk);
    chk("one_done", done2, 1);
    chk("one_idle_vld", dvalid2, 0);
    chk("one_idle_dout", dout2, 0);
    @(negedge clk);
    chk("one_done_pulse", done2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lea_block_serializer.md
LEA_BLOCK_SERIALIZER -- requirements
Module: lea_block_serializer

Interface
REQ-001 The block SHALL have parameter NBYTES, default 16, giving the number of bytes per block; the block width is 8*NBYTES.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 sends byte 0 (Blk[7:0]) first; 1 sends byte NBYTES-1 first.
REQ-003 The block SHALL have port Clk, input, width 1: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port Ld, input, width 1: block load strobe.
REQ-006 The block SHALL have port Blk, input, width 8*NBYTES: the block to send (LEA ciphertext or plaintext).
REQ-007 The block SHALL have port Busy, output, width 1: a block is held and not fully sent.
REQ-008 The block SHALL have port Dout, output, width 8: the current byte.
REQ-009 The block SHALL have port Dvalid, output, width 1: Dout is valid.
REQ-010 The block SHALL have port Dready, input, width 1: the downstream consumer accepts Dout.
REQ-011 The block SHALL have port Last, output, width 1: Dout is the final byte of the block.
REQ-012 The block SHALL have port Done, output, width 1: one-cycle pulse after the final byte is accepted.

Function
REQ-013 The block SHALL use a two-state FSM: IDLE (Busy=0, Dvalid=0) and SEND (Busy=1, Dvalid=1).
REQ-014 In IDLE with Ld=1 at edge N, the block SHALL capture Blk, clear the byte index to 0, and enter SEND, so Dvalid=1 with the first byte from cycle N+1 (1-cycle latency).
REQ-015 While in SEND, the block SHALL ignore Ld and leave Blk uncaptured; there is no queuing.
REQ-016 A transfer SHALL occur on an edge where Dvalid=1 and Dready=1; only then SHALL the byte index advance by 1.
REQ-017 While Dvalid=1 and Dready=0, Dout and Last SHALL hold stable for any number of cycles.
REQ-018 Byte k of the stream SHALL be Blk[8k+7:8k] when MSB_FIRST=0, and Blk[8(NBYTES-1-k)+7:8(NBYTES-1-k)] when MSB_FIRST=1.
REQ-019 Last SHALL be 1 exactly when Dvalid=1 and the index equals NBYTES-1.
REQ-020 A transfer with Last=1 SHALL return the FSM to IDLE; the index SHALL NOT wrap to 0 in SEND; Done SHALL be 1 for exactly the next cycle.
REQ-021 Ld=1 in the same cycle as the Last transfer SHALL be ignored, because the FSM is still in SEND; Ld is accepted from the following cycle.
REQ-022 Dready while in IDLE SHALL have no effect.
REQ-023 Dout SHALL be 8'h00 whenever Dvalid=0.
REQ-024 The index counter SHALL be ceil(log2(NBYTES)) bits wide; NBYTES of 1 SHALL produce a single byte with Last=1.

Reset
REQ-025 Reset=1 SHALL immediately and asynchronously force IDLE, index=0, the captured block to 0, and Busy=0, Dvalid=0, Last=0, Done=0, Dout=8'h00.
REQ-026 Reset asserted mid-block SHALL abort the block; no remaining bytes are sent after Reset falls.
REQ-027 The first Ld SHALL be honoured on the first rising edge after Reset deasserts.

Structure
REQ-028 The shared package lea_pkg SHALL hold LEA_BLOCK_W=128, LEA_BYTE_W=8, and the FSM state type (IDLE, SEND).
REQ-029 The index counter SHALL be a sub-module lea_byte_counter (Clk, Reset, clear, inc, count, at_max); the remaining logic stays in lea_block_serializer.

Verification
REQ-030 Basic: Blk=128'h0F0E0D0C_0B0A0908_07060504_03020100, MSB_FIRST=0, Dready=1 -> Dout 00,01,...,0F on 16 consecutive cycles; Last only on 0F; Done one cycle later.
REQ-031 Back-pressure: same block, Dready toggles 1,0,0,1,... -> the byte sequence is unchanged, Dout is stable during stalls, and the total transfer count is 16.
REQ-032 MSB_FIRST=1, same block -> first byte 0F, last byte 00.
REQ-033 Ld during SEND with Blk=all-FF, including Ld in the Last cycle -> the stream is unaffected, no byte FF is sent, and the FSM is IDLE afterwards.
REQ-034 Reset pulse after the 5th transfer -> outputs are zero within the same cycle; a new Ld with Blk=128'h1 then yields 01,00,...,00.
REQ-035 Back-to-back: Ld on the cycle after Done -> the second block starts with 1-cycle latency and no byte from the first block repeats.
